// File: rtl/ahbl_stream_loader_if.sv
// Stream and AHB-Lite master signal bundle for ahbl_stream_loader.
// The master modport is the loader side; the slave modport is the stream source plus bus slave.
interface ahbl_stream_loader_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [W_DATA-1:0] in_data;

   logic              ahblm_hready;
   logic              ahblm_hresp;
   logic [W_DATA-1:0] ahblm_hrdata;
   logic [W_ADDR-1:0] ahblm_haddr;
   logic              ahblm_hwrite;
   logic [1:0]        ahblm_htrans;
   logic [2:0]        ahblm_hsize;
   logic [2:0]        ahblm_hburst;
   logic [3:0]        ahblm_hprot;
   logic              ahblm_hmastlock;
   logic [W_DATA-1:0] ahblm_hwdata;

   modport master (
      input  in_valid, in_data,
      input  ahblm_hready, ahblm_hresp, ahblm_hrdata,
      output in_ready,
      output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
      output ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
   );

   modport slave (
      output in_valid, in_data,
      output ahblm_hready, ahblm_hresp, ahblm_hrdata,
      input  in_ready,
      input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
      input  ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
   );
endinterface

// File: rtl/ahbl_stream_loader.sv
// AHB-Lite write initiator: copies a valid/ready word stream to consecutive word
// addresses using pipelined SINGLE NONSEQ transfers, one word per cycle at zero wait.
module ahbl_stream_loader #(
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter int W_COUNT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W_ADDR-1:0]   start_addr,
   input  logic [W_COUNT-1:0]  word_count,
   output logic                busy,
   output logic                done,
   output logic                err,
   ahbl_stream_loader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t             state_q, state_d;
   logic [W_ADDR-1:0]  addr_q, addr_d;
   logic [W_COUNT-1:0] remaining_q, remaining_d;
   logic [W_DATA-1:0]  hwdata_q, hwdata_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               in_ready_c;
   logic               accept;
   logic [1:0]         htrans_c;
   logic               unused_inputs;

   assign unused_inputs = ^{bus.ahblm_hrdata, start_addr[1:0]};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      hwdata_d    = hwdata_q;
      done_d      = 1'b0;
      err_d       = err_q;
      in_ready_c  = 1'b0;
      accept      = 1'b0;
      htrans_c    = HTRANS_IDLE;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               err_d       = 1'b0;
               addr_d      = {start_addr[W_ADDR-1:2], 2'b00};
               remaining_d = word_count;
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            // htrans ignores hready so the address phase stays put across wait states
            if (remaining_q != '0 && !bus.ahblm_hresp) begin
               in_ready_c = bus.ahblm_hready;
               if (bus.in_valid) begin
                  htrans_c = HTRANS_NONSEQ;
               end
            end
            accept = bus.in_valid && in_ready_c;

            if (bus.ahblm_hresp) begin
               if (bus.ahblm_hready) begin
                  state_d     = IDLE;
                  remaining_d = '0;
                  err_d       = 1'b1;
                  done_d      = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end else if (accept) begin
               hwdata_d    = bus.in_data;
               addr_d      = addr_q + W_ADDR'(4);
               remaining_d = remaining_q - W_COUNT'(1);
               if (remaining_q == W_COUNT'(1)) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (bus.ahblm_hready) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (bus.ahblm_hresp) begin
                  err_d = 1'b1;
               end
            end else if (bus.ahblm_hresp) begin
               state_d = ERR;
            end
         end

         ERR: begin
            // second cycle of the two-cycle ERROR response closes the load
            if (bus.ahblm_hready) begin
               state_d     = IDLE;
               remaining_d = '0;
               err_d       = 1'b1;
               done_d      = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         hwdata_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         hwdata_q    <= hwdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign err  = err_q;

   assign bus.in_ready        = in_ready_c;
   assign bus.ahblm_htrans    = htrans_c;
   assign bus.ahblm_haddr     = addr_q;
   assign bus.ahblm_hwdata    = hwdata_q;
   assign bus.ahblm_hwrite    = 1'b1;
   assign bus.ahblm_hsize     = 3'b010;
   assign bus.ahblm_hburst    = 3'b000;
   assign bus.ahblm_hprot     = 4'b0011;
   assign bus.ahblm_hmastlock = 1'b0;
endmodule

// File: tb/tb_ahbl_stream_loader.sv
// Bench for ahbl_stream_loader: stream source and AHB-Lite SRAM slave models with a
// write scoreboard, plus per-scenario cycle-accurate checks.
module tb_ahbl_stream_loader;
   localparam int W_ADDR  = 32;
   localparam int W_DATA  = 32;
   localparam int W_COUNT = 16;
   localparam logic [1:0] HT_I = 2'b00;
   localparam logic [1:0] HT_N = 2'b10;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [W_ADDR-1:0]  start_addr = '0;
   logic [W_COUNT-1:0] word_count = '0;
   logic               busy, done, err;

   ahbl_stream_loader_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

   ahbl_stream_loader #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_COUNT(W_COUNT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [31:0]       src_q[$];
   bit                gap_mode = 1'b0;
   logic [W_ADDR-1:0] exp_addr_q[$];
   logic [31:0]       exp_data_q[$];
   logic [31:0]       mem [logic [W_ADDR-1:0]];
   int                nonseq_cnt = 0;
   int                err_xfers = 0;
   int                cfg_wait_idx = -1;
   int                cfg_wait_n = 0;
   int                cfg_err_idx = -1;

   // SRAM slave: response chosen per data-phase index; completed writes go to the scoreboard
   task automatic slave_bfm();
      bit                dp_valid = 1'b0;
      logic [W_ADDR-1:0] dp_addr = '0;
      int                dp_idx = 0;
      int                dp_cyc = 0;
      logic [W_ADDR-1:0] ea;
      logic [31:0]       ed;
      forever begin
         @(posedge clk); #1;
         bus.ahblm_hready = 1'b1;
         bus.ahblm_hresp  = 1'b0;
         if (!rst && dp_valid) begin
            if (dp_idx == cfg_wait_idx && dp_cyc < cfg_wait_n) begin
               bus.ahblm_hready = 1'b0;
            end else if (dp_idx == cfg_err_idx) begin
               bus.ahblm_hresp  = 1'b1;
               bus.ahblm_hready = (dp_cyc >= 1);
            end
         end
         @(negedge clk);
         if (rst) begin
            dp_valid = 1'b0;
         end else if (bus.ahblm_hready) begin
            if (dp_valid) begin
               if (bus.ahblm_hresp) begin
                  err_xfers++;
               end else begin
                  mem[dp_addr] = bus.ahblm_hwdata;
                  total++;
                  if (exp_addr_q.size() == 0) begin
                     bad++;
                     $display("FAIL sb_write: got addr=%h data=%h, expected no write", dp_addr, bus.ahblm_hwdata);
                  end else begin
                     ea = exp_addr_q.pop_front();
                     ed = exp_data_q.pop_front();
                     if (dp_addr !== ea || bus.ahblm_hwdata !== ed) begin
                        bad++;
                        $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                                 dp_addr, bus.ahblm_hwdata, ea, ed);
                     end
                  end
               end
            end
            if (bus.ahblm_htrans == HT_N) begin
               dp_valid = 1'b1;
               dp_addr  = bus.ahblm_haddr;
               dp_idx   = nonseq_cnt;
               nonseq_cnt++;
               dp_cyc   = 0;
            end else begin
               dp_valid = 1'b0;
            end
         end else begin
            dp_cyc++;
         end
      end
   endtask

   // Stream source: holds each word until accepted; gap_mode inserts one idle cycle after each
   task automatic src_bfm();
      bit acc_prev = 1'b0;
      bit skip;
      forever begin
         @(posedge clk); #1;
         skip = 1'b0;
         if (acc_prev && src_q.size() != 0) begin
            void'(src_q.pop_front());
            skip = gap_mode;
         end
         if (src_q.size() != 0 && !skip) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src_q[0];
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         acc_prev = bus.in_valid && bus.in_ready && !rst;
      end
   endtask

   task automatic load_words(input logic [31:0] addr, input int n, input logic [31:0] base, input int n_exp);
      for (int i = 0; i < n; i++) begin
         src_q.push_back(base + 32'(i));
         if (i < n_exp) begin
            exp_addr_q.push_back(addr + 32'(4 * i));
            exp_data_q.push_back(base + 32'(i));
         end
      end
   endtask

   // Returns #1 after the edge that samples start (first cycle of the load)
   task automatic do_start(input logic [31:0] addr, input logic [15:0] cnt);
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = addr;
      word_count = cnt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, done, err} !== 3'b000) begin
         bad++; $display("FAIL reset_status: got busy/done/err=%b, expected 000", {busy, done, err});
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready);
      end
      total++;
      if (bus.ahblm_htrans !== HT_I) begin
         bad++; $display("FAIL reset_htrans: got %b, expected 00", bus.ahblm_htrans);
      end
      total++;
      if (bus.ahblm_haddr !== 32'h0 || bus.ahblm_hwdata !== 32'h0) begin
         bad++; $display("FAIL reset_addr_data: got haddr=%h hwdata=%h, expected 0/0", bus.ahblm_haddr, bus.ahblm_hwdata);
      end
      total++;
      if ({bus.ahblm_hwrite, bus.ahblm_hsize, bus.ahblm_hburst, bus.ahblm_hprot, bus.ahblm_hmastlock}
          !== {1'b1, 3'b010, 3'b000, 4'b0011, 1'b0}) begin
         bad++; $display("FAIL const_ctrl: got hwrite=%b hsize=%b hburst=%b hprot=%b hmastlock=%b, expected 1/010/000/0011/0",
                         bus.ahblm_hwrite, bus.ahblm_hsize, bus.ahblm_hburst, bus.ahblm_hprot, bus.ahblm_hmastlock);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      load_words(32'h100, 3, 32'hA0, 3);
      do_start(32'h100, 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (bus.ahblm_htrans !== ((k < 3) ? HT_N : HT_I)) begin
            bad++; $display("FAIL zw_htrans[%0d]: got %b", k, bus.ahblm_htrans);
         end
         if (k < 3) begin
            total++;
            if (bus.ahblm_haddr !== 32'h100 + 32'(4 * k)) begin
               bad++; $display("FAIL zw_haddr[%0d]: got %h, expected %h", k, bus.ahblm_haddr, 32'h100 + 32'(4 * k));
            end
         end
         if (k >= 1 && k <= 3) begin
            total++;
            if (bus.ahblm_hwdata !== 32'hA0 + 32'(k - 1)) begin
               bad++; $display("FAIL zw_hwdata[%0d]: got %h, expected %h", k, bus.ahblm_hwdata, 32'hA0 + 32'(k - 1));
            end
         end
         total++;
         if (done !== (k == 4) || busy !== (k < 4)) begin
            bad++; $display("FAIL zw_done_busy[%0d]: got done=%b busy=%b, expected %b/%b", k, done, busy, (k == 4), (k < 4));
         end
      end
      total++;
      if (!mem.exists(32'h108) || mem[32'h108] !== 32'hA2 || mem[32'h100] !== 32'hA0) begin
         bad++; $display("FAIL zw_sram: got mem[100]=%h mem[108]=%h, expected a0/a2", mem[32'h100], mem[32'h108]);
      end
      total++;
      if (exp_addr_q.size() != 0) begin
         bad++; $display("FAIL zw_pending: got %0d writes outstanding, expected 0", exp_addr_q.size());
      end
   endtask

   task automatic test_wait_states();
      logic [1:0]  e_ht  [7] = '{HT_N, HT_N, HT_N, HT_N, HT_N, HT_I, HT_I};
      logic [31:0] e_ad  [7] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h0, 32'h0};
      logic [31:0] e_wd  [7] = '{32'h0, 32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2, 32'h0};
      logic        e_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      cfg_wait_idx = nonseq_cnt + 1;
      cfg_wait_n   = 2;
      load_words(32'h100, 3, 32'hA0, 3);
      do_start(32'h100, 3);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         total++;
         if (bus.ahblm_htrans !== e_ht[k] || bus.in_ready !== e_rdy[k]) begin
            bad++; $display("FAIL ws_htrans_ready[%0d]: got %b/%b, expected %b/%b", k, bus.ahblm_htrans, bus.in_ready, e_ht[k], e_rdy[k]);
         end
         if (e_ht[k] == HT_N) begin
            total++;
            if (bus.ahblm_haddr !== e_ad[k]) begin
               bad++; $display("FAIL ws_haddr[%0d]: got %h, expected %h", k, bus.ahblm_haddr, e_ad[k]);
            end
         end
         if (k >= 1 && k <= 5) begin
            total++;
            if (bus.ahblm_hwdata !== e_wd[k]) begin
               bad++; $display("FAIL ws_hwdata[%0d]: got %h, expected %h", k, bus.ahblm_hwdata, e_wd[k]);
            end
         end
         total++;
         if (done !== (k == 6)) begin
            bad++; $display("FAIL ws_done[%0d]: got %b, expected %b", k, done, (k == 6));
         end
      end
      cfg_wait_idx = -1;
      total++;
      if (exp_addr_q.size() != 0) begin
         bad++; $display("FAIL ws_pending: got %0d writes outstanding, expected 0", exp_addr_q.size());
      end
   endtask

   task automatic test_stream_gaps();
      gap_mode = 1'b1;
      load_words(32'h300, 4, 32'hB0, 4);
      do_start(32'h300, 4);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         total++;
         if (bus.ahblm_htrans !== ((k % 2 == 0 && k < 8) ? HT_N : HT_I)) begin
            bad++; $display("FAIL gap_htrans[%0d]: got %b", k, bus.ahblm_htrans);
         end
         if (k % 2 == 0 && k < 8) begin
            total++;
            if (bus.ahblm_haddr !== 32'h300 + 32'(2 * k)) begin
               bad++; $display("FAIL gap_haddr[%0d]: got %h, expected %h", k, bus.ahblm_haddr, 32'h300 + 32'(2 * k));
            end
         end
         if (k % 2 == 1) begin
            total++;
            if (bus.ahblm_hwdata !== 32'hB0 + 32'(k / 2)) begin
               bad++; $display("FAIL gap_hwdata[%0d]: got %h, expected %h", k, bus.ahblm_hwdata, 32'hB0 + 32'(k / 2));
            end
         end
         total++;
         if (done !== (k == 8)) begin
            bad++; $display("FAIL gap_done[%0d]: got %b, expected %b", k, done, (k == 8));
         end
      end
      gap_mode = 1'b0;
      total++;
      if (exp_addr_q.size() != 0) begin
         bad++; $display("FAIL gap_pending: got %0d writes outstanding, expected 0", exp_addr_q.size());
      end
   endtask

   task automatic test_error();
      int base_ns = nonseq_cnt;
      int base_err = err_xfers;
      cfg_err_idx = nonseq_cnt + 1;
      load_words(32'h400, 4, 32'hC0, 1);
      do_start(32'h400, 4);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if (bus.ahblm_htrans !== ((k < 2) ? HT_N : HT_I)) begin
            bad++; $display("FAIL err_htrans[%0d]: got %b", k, bus.ahblm_htrans);
         end
         total++;
         if (done !== (k == 4) || err !== (k >= 4) || busy !== (k < 4)) begin
            bad++; $display("FAIL err_status[%0d]: got done=%b err=%b busy=%b, expected %b/%b/%b",
                            k, done, err, busy, (k == 4), (k >= 4), (k < 4));
         end
         if (k == 2) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
               bad++; $display("FAIL err_in_ready: got %b, expected 0", bus.in_ready);
            end
         end
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (nonseq_cnt - base_ns !== 2 || err_xfers - base_err !== 1) begin
         bad++; $display("FAIL err_xfers: got nonseq=%0d errors=%0d, expected 2/1", nonseq_cnt - base_ns, err_xfers - base_err);
      end
      total++;
      if (err !== 1'b1) begin
         bad++; $display("FAIL err_sticky: got %b, expected 1", err);
      end
      total++;
      if (exp_addr_q.size() != 0) begin
         bad++; $display("FAIL err_pending: got %0d writes outstanding, expected 0", exp_addr_q.size());
      end
      src_q.delete();
      cfg_err_idx = -1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_boundary();
      int base_ns = nonseq_cnt;
      do_start(32'h700, 16'd0);
      @(negedge clk);
      total++;
      if ({done, busy, err} !== 3'b100 || bus.ahblm_htrans !== HT_I) begin
         bad++; $display("FAIL zero_cnt: got done/busy/err=%b htrans=%b, expected 100/00", {done, busy, err}, bus.ahblm_htrans);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL zero_cnt_pulse: got done=%b, expected 0", done);
      end
      @(posedge clk); #1;
      total++;
      if (nonseq_cnt !== base_ns) begin
         bad++; $display("FAIL zero_cnt_nonseq: got %0d transfers, expected 0", nonseq_cnt - base_ns);
      end

      load_words(32'hFFFF_FFFC, 2, 32'hD0, 2);
      do_start(32'hFFFF_FFFC, 2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 2) begin
            total++;
            if (bus.ahblm_htrans !== HT_N || bus.ahblm_haddr !== ((k == 0) ? 32'hFFFF_FFFC : 32'h0)) begin
               bad++; $display("FAIL wrap_addr[%0d]: got htrans=%b haddr=%h", k, bus.ahblm_htrans, bus.ahblm_haddr);
            end
         end
         total++;
         if (done !== (k == 3)) begin
            bad++; $display("FAIL wrap_done[%0d]: got %b, expected %b", k, done, (k == 3));
         end
      end
      total++;
      if (!mem.exists(32'h0) || mem[32'h0] !== 32'hD1) begin
         bad++; $display("FAIL wrap_sram: got mem[0]=%h, expected d1", mem[32'h0]);
      end

      base_ns = nonseq_cnt;
      load_words(32'h500, 3, 32'hE0, 3);
      do_start(32'h500, 3);
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = 32'h900;
      word_count = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 2; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) begin
            total++;
            if (bus.ahblm_htrans !== HT_N || bus.ahblm_haddr !== 32'h508) begin
               bad++; $display("FAIL busy_start_addr: got htrans=%b haddr=%h, expected 10/508", bus.ahblm_htrans, bus.ahblm_haddr);
            end
         end
         total++;
         if (done !== (k == 4) || busy !== (k < 4)) begin
            bad++; $display("FAIL busy_start_done[%0d]: got done=%b busy=%b, expected %b/%b", k, done, busy, (k == 4), (k < 4));
         end
      end
      @(posedge clk); #1;
      total++;
      if (nonseq_cnt - base_ns !== 3 || exp_addr_q.size() != 0) begin
         bad++; $display("FAIL busy_start_xfers: got nonseq=%0d pending=%0d, expected 3/0", nonseq_cnt - base_ns, exp_addr_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int  base_ns = nonseq_cnt;
      bit  got = 1'b0;
      load_words(32'h600, 8, 32'hF0, 1);
      do_start(32'h600, 8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      src_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.ahblm_htrans !== HT_I || {busy, done, bus.in_ready} !== 3'b000 || bus.ahblm_haddr !== 32'h0) begin
         bad++; $display("FAIL mid_reset: got htrans=%b busy/done/in_ready=%b haddr=%h, expected 00/000/0",
                         bus.ahblm_htrans, {busy, done, bus.in_ready}, bus.ahblm_haddr);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (nonseq_cnt - base_ns !== 2 || exp_addr_q.size() != 0) begin
         bad++; $display("FAIL mid_reset_xfers: got nonseq=%0d pending=%0d, expected 2/0", nonseq_cnt - base_ns, exp_addr_q.size());
      end

      load_words(32'h800, 2, 32'h80, 2);
      do_start(32'h800, 2);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      total++;
      if (!got || exp_addr_q.size() != 0) begin
         bad++; $display("FAIL after_reset_load: got done_seen=%b pending=%0d, expected 1/0", got, exp_addr_q.size());
      end
   endtask

   initial begin
      bus.in_valid     = 1'b0;
      bus.in_data      = '0;
      bus.ahblm_hready = 1'b1;
      bus.ahblm_hresp  = 1'b0;
      bus.ahblm_hrdata = '0;
      fork
         slave_bfm();
         src_bfm();
      join_none
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stream_gaps();
      test_error();
      test_boundary();
      test_reset_mid_load();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no end of test by 50000ns, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ahbl_stream_loader.md
AHBL_STREAM_LOADER -- requirements
Module: ahbl_stream_loader

Interface
REQ-001 Parameter W_ADDR, default 32, AHB-Lite address width.
REQ-002 Parameter W_DATA, default 32, AHB-Lite data width; only 32 is supported.
REQ-003 Parameter W_COUNT, default 16, width of the word count.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
REQ-007 start_addr  in  W_ADDR  first byte address; bits [1:0] ignored (forced 00).
REQ-008 word_count  in  W_COUNT  number of 32-bit words to write; sampled on start.
REQ-009 in_valid / in_ready / in_data  in / out / in  1 / 1 / 32  word stream, valid/ready handshake.
REQ-010 busy  out  1  load in progress.
REQ-011 done  out  1  one-cycle pulse at the end of a load.
REQ-012 err  out  1  sticky; set when the slave returns an error.
REQ-013 ahblm_hready / ahblm_hresp / ahblm_hrdata  in  1 / 1 / 32  AHB-Lite master inputs; hrdata is unused.
REQ-014 ahblm_haddr / ahblm_hwrite / ahblm_htrans / ahblm_hsize / ahblm_hburst / ahblm_hprot / ahblm_hmastlock / ahblm_hwdata  out  W_ADDR / 1 / 2 / 3 / 3 / 4 / 1 / 32  AHB-Lite master outputs.

Function
REQ-015 The block SHALL be an AHB-Lite initiator that writes each accepted stream word to consecutive word addresses starting at start_addr.
REQ-016 Constant outputs SHALL be: hwrite=1, hsize=3'b010, hburst=3'b000 (SINGLE), hprot=4'b0011, hmastlock=0.
REQ-017 The state machine SHALL have states IDLE, RUN, DRAIN and ERR.
  - IDLE->RUN on start with word_count!=0.
  - IDLE with start and word_count==0: done pulses next cycle; no bus transfers; busy stays 0.
REQ-018 In RUN the block SHALL drive htrans=NONSEQ and haddr=current address when remaining!=0, in_valid=1 and hresp=0; otherwise it SHALL drive htrans=IDLE.
REQ-019 in_ready SHALL equal (state==RUN && remaining!=0 && hready && !hresp); a word is accepted when in_valid && in_ready.
REQ-020 The stream source SHALL hold in_valid and in_data stable until the word is accepted, which keeps htrans/haddr stable while hready=0.
REQ-021 On acceptance the block SHALL:
  - register in_data into hwdata for the following data phase, holding it while hready=0;
  - advance the address by 4, wrapping modulo 2^W_ADDR;
  - decrement remaining.
REQ-022 Address and data phases SHALL pipeline: word N's address phase overlaps word N-1's data phase, giving one word per cycle at zero wait states.
REQ-023 When the last word is accepted, the block SHALL enter DRAIN.
REQ-024 In DRAIN the block SHALL drive htrans=IDLE; on the cycle hready=1 completes the final data phase it SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-025 busy SHALL be 1 in RUN, DRAIN and ERR.
REQ-026 Error handling, first error cycle (hresp=1, hready=0): the block SHALL drive htrans=IDLE and accept no word.
REQ-027 Error handling, second error cycle (hresp=1, hready=1): the block SHALL set err, pulse done, clear busy, go to IDLE and discard the remaining count.
REQ-028 err SHALL be cleared only by rst or by the next accepted start.
REQ-029 A start asserted while busy=1 SHALL be ignored, with no effect on address, count or outputs.

Reset
REQ-030 While rst=1 at a rising edge: state=IDLE, busy=0, done=0, err=0, in_ready=0, htrans=IDLE, haddr=0, hwdata=0, remaining=0.
REQ-031 Reset asserted mid-load SHALL abandon the load; htrans SHALL be IDLE from the first cycle after the reset edge.

Verification
REQ-032 Zero-wait load: start_addr=0x100, word_count=3, words 0xA0,0xA1,0xA2 always valid -> NONSEQ at 0x100/0x104/0x108 on 3 consecutive cycles; hwdata A0/A1/A2 one cycle later; done 4 cycles after the first NONSEQ; SRAM holds the words.
REQ-033 Wait states: slave holds hready=0 for 2 cycles during the second data phase -> haddr=0x108 and hwdata=0xA1 held stable; no word lost or duplicated.
REQ-034 Stream gaps: in_valid toggles 1,0,1,0 -> htrans IDLE in gap cycles; addresses remain contiguous.
REQ-035 Error: slave returns a two-cycle ERROR on word 2 of 4 -> htrans=IDLE in the first error cycle; err=1 and done pulses after the second; no further NONSEQ.
REQ-036 Boundary: word_count=0 -> done one cycle after start, no NONSEQ; start_addr=0xFFFF_FFFC with count 2 -> second address 0x0000_0000; start during busy is ignored.
